// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for 7-segment display logic.
//   SEG_TABLE   : hex digit -> active-low {g,f,e,d,c,b,a} pattern
//   SEG_BLANK   : all segments off
//   MAX_DIGITS  : widest anode vector any user may request
//   an_select() : active-low one-hot anode vector, MAX_DIGITS wide; users
//                 slice the low NUM_DIGITS bits.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  // element [n] is the pattern for digit n (index 0 is the rightmost entry)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [MAX_DIGITS-1:0] an_select(input logic [2:0] idx);
    an_select = ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low 7-segment pattern.
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, active low
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed common-anode 7-segment driver with
// load-strobed shadow register, per-digit dp and blink, leading-zero
// suppression, global blank and an all-anodes-off guard at slot start.
//   clk, rst    : clock, asynchronous active-high reset
//   digits_in   : hex nibbles, [3:0] = digit 0 (rightmost, an[0])
//   dp_in       : per-digit decimal point request, 1 = lit
//   blink_en    : per-digit blink enable
//   lz_suppress : blank leading zero digits
//   blank_in    : all digits dark
//   load        : 1-cycle strobe capturing all display inputs
//   seg, dp, an : registered, active-low pin drives
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 16,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  input  logic                    blank_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [GW-1:0]           guard;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_hidden;

  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blink_sh;
  logic                    lz_sh;
  logic                    blank_sh;

  logic                    tick;
  logic [IW-1:0]           idx_n;
  logic [GW-1:0]           guard_n;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    digit_off;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;
  logic [MAX_DIGITS-1:0]   an_wide;

  // Outputs are computed from the post-edge slot state so that the guard
  // lasts exactly GUARD cycles and GUARD=0 drives the slot on the tick edge.
  always_comb begin
    tick    = (pre == PW'(SCAN_DIV - 1));
    idx_n   = idx;
    guard_n = guard;
    if (tick) begin
      idx_n   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      guard_n = GW'(GUARD);
    end else if (guard != '0) begin
      guard_n = guard - 1'b1;
    end
  end

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the shadow are all zero
  always_comb begin
    upper_zero = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j >= i && digits_sh[4*j +: 4] != 4'h0) upper_zero[i] = 1'b0;
      end
    end
  end

  always_comb begin
    nibble    = digits_sh[{idx_n, 2'b00} +: 4];
    digit_off = blank_sh
              | (blink_sh[idx_n] & blink_hidden)
              | (lz_sh & (idx_n != '0) & upper_zero[idx_n]);
    an_wide   = an_select(3'(idx_n));
  end

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      idx          <= '0;
      guard        <= GW'(GUARD);
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      digits_sh    <= '0;
      dp_sh        <= '0;
      blink_sh     <= '0;
      lz_sh        <= 1'b0;
      blank_sh     <= 1'b0;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
      an           <= '1;
    end else begin
      pre   <= tick ? '0 : pre + 1'b1;
      idx   <= idx_n;
      guard <= guard_n;

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (load) begin
        digits_sh <= digits_in;
        dp_sh     <= dp_in;
        blink_sh  <= blink_en;
        lz_sh     <= lz_suppress;
        blank_sh  <= blank_in;
      end

      if (guard_n != '0) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        // anode stays on for blanked digits to keep brightness uniform
        an  <= an_wide[NUM_DIGITS-1:0];
        seg <= digit_off ? SEG_BLANK : seg_dec;
        dp  <= digit_off ? 1'b1 : ~dp_sh[idx_n];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int N = 4;
  localparam int S = 4;
  localparam int G = 1;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_en = '0;
  logic        lz_suppress = 1'b0;
  logic        blank_in = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (S),
    .GUARD      (G),
    .BLINK_DIV  (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blink_en    (blink_en),
    .lz_suppress (lz_suppress),
    .blank_in    (blank_in),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: n = edges since reset release. After edge n the scan is in
  // slot (n/S) mod N at offset n mod S; the first G offsets are dark. Blink phase
  // used at edge n is hidden when floor((n-1)/B) is odd.
  int          n;
  int          d;
  bit          hidden;
  bit          off;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_bl;
  logic        m_lz, m_blank;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'hF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
      m_dig = '0; m_dp = '0; m_bl = '0; m_lz = 1'b0; m_blank = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      n = n + 1;
      d = (n / S) % N;
      hidden = (((n - 1) / B) % 2) == 1;
      if ((n % S) < G) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        off = m_blank || (m_bl[d] && hidden) || (m_lz && d > 0 && (m_dig >> (4 * d)) == 0);
        e_an = 4'hF;
        e_an[d] = 1'b0;
        e_seg = off ? 7'h7F : dec_tab[(m_dig >> (4 * d)) & 16'hF];
        e_dp = off ? 1'b1 : ~m_dp[d];
      end
      if (load) begin
        m_dig = digits_in; m_dp = dp_in; m_bl = blink_en;
        m_lz = lz_suppress; m_blank = blank_in;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({seg, dp, an} !== {e_seg, e_dp, e_an}) begin
        errors++;
        $display("FAIL model t=%0t: got seg=%h dp=%b an=%b, want seg=%h dp=%b an=%b",
                 $time, seg, dp, an, e_seg, e_dp, e_an);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // wait (bounded) for a negedge where an equals target
  task automatic wait_an(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (an === target) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_an: an never reached %b within %0d cycles", target, budget);
    end
  endtask

  task automatic slot_seg(input string name, input logic [3:0] target, input logic [6:0] want);
    bit ok;
    wait_an(target, 2 * S * N, ok);
    if (ok) chk(name, {9'h0, seg}, {9'h0, want});
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] blv,
                         input logic lz, input logic blk);
    @(negedge clk);
    digits_in = dg; dp_in = dpv; blink_en = blv; lz_suppress = lz; blank_in = blk;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int cnt;
    bit saw_on, saw_off;

    repeat (3) @(negedge clk);
    chk("reset_dark", {seg, dp, an, 4'h0}, {7'h7F, 1'b1, 4'hF, 4'h0});
    rst = 1'b0;
    cmp_en = 1'b1;
    cnt = 0;
    ok = 1'b0;
    while (!ok && cnt < S + G + 1) begin
      @(negedge clk);
      cnt++;
      if (an === 4'b1110) ok = 1'b1;
    end
    chk("first_slot_digit0", {15'h0, ok}, 16'h1);

    // scan and decode
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b0);
    slot_seg("dec_d0", 4'b1110, 7'h0E);
    slot_seg("dec_d1", 4'b1101, 7'h08);
    slot_seg("dec_d2", 4'b1011, 7'h24);
    slot_seg("dec_d3", 4'b0111, 7'h79);
    wait_an(4'b1111, 2 * S * N, ok);
    wait_an(4'b1110, 2 * S * N, ok);
    cnt = 0;
    while (an === 4'b1110 && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    chk("slot_len", 16'(cnt), 16'd3);
    chk("guard_dark", {12'h0, an}, 16'h000F);

    // leading-zero suppression
    do_load(16'h0040, 4'h0, 4'h0, 1'b1, 1'b0);
    slot_seg("lz_d3", 4'b0111, 7'h7F);
    slot_seg("lz_d2", 4'b1011, 7'h7F);
    slot_seg("lz_d1", 4'b1101, 7'h19);
    slot_seg("lz_d0", 4'b1110, 7'h40);
    do_load(16'h0000, 4'hF, 4'h0, 1'b1, 1'b0);
    slot_seg("lz0_d1", 4'b1101, 7'h7F);
    chk("lz0_d1_dp", {15'h0, dp}, 16'h1);
    slot_seg("lz0_d0", 4'b1110, 7'h40);

    // blink and dp
    do_load(16'h1234, 4'b0100, 4'b0010, 1'b0, 1'b0);
    saw_on = 1'b0; saw_off = 1'b0;
    for (int i = 0; i < 3 * B; i++) begin
      @(negedge clk);
      if (an === 4'b1101 && seg === 7'h30) saw_on = 1'b1;
      if (an === 4'b1101 && seg === 7'h7F) saw_off = 1'b1;
    end
    chk("blink_both_phases", {14'h0, saw_on, saw_off}, 16'h3);
    wait_an(4'b1011, 2 * S * N, ok);
    if (ok) chk("dp_d2", {15'h0, dp}, 16'h0);
    wait_an(4'b1110, 2 * S * N, ok);
    if (ok) chk("dp_d0", {15'h0, dp}, 16'h1);

    // load gating and blank
    @(negedge clk);
    digits_in = 16'hFFFF;
    repeat (2 * S * N) @(negedge clk);
    slot_seg("no_load_d0", 4'b1110, 7'h19);
    do_load(16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0);
    slot_seg("load_d0", 4'b1110, 7'h0E);
    do_load(16'h8888, 4'hF, 4'h0, 1'b0, 1'b1);
    slot_seg("blank_d0", 4'b1110, 7'h7F);
    chk("blank_dp", {15'h0, dp}, 16'h1);
    slot_seg("blank_d3", 4'b0111, 7'h7F);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      digits_in   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'h00FF;
      dp_in       = 4'($urandom);
      blink_en    = 4'($urandom);
      lz_suppress = 1'($urandom);
      blank_in    = ($urandom_range(0, 7) == 0);
      load        = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    load = 1'b0;

    // reset mid-slot: dark immediately, scan restarts at digit 0
    wait_an(4'b1101, 2 * S * N, ok);
    #2 rst = 1'b1;
    #1 chk("async_reset_dark", {seg, dp, an, 4'h0}, {7'h7F, 1'b1, 4'hF, 4'h0});
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    ok = 1'b0;
    while (!ok && cnt < S + G + 1) begin
      @(negedge clk);
      cnt++;
      if (an === 4'b1110) ok = 1'b1;
    end
    chk("restart_digit0", {15'h0, ok}, 16'h1);
    repeat (2 * S * N) @(negedge clk);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
